// File: rtl/uart_word_tx_if.sv
// Word-side handshake between the core and uart_word_tx: write strobe in,
// completion/occupancy status out.
interface uart_word_tx_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   data_send;
  logic          data_send_valid;
  logic          data_send_done;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output data_send,
    output data_send_valid,
    input  data_send_done,
    input  fifo_full,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  data_send,
    input  data_send_valid,
    output data_send_done,
    output fifo_full,
    output fifo_count,
    output overflow
  );
endinterface

// File: rtl/uart_word_tx.sv
// Buffers 16-bit words in a FIFO and sends each as two bytes to a UART TX.
// Define UART_WORD_TX_MSB_FIRST_EN to send [15:8] before [7:0].
module uart_word_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstb,
  uart_word_tx_if.slave word_if,
  output logic [7:0]    tx_byte,
  output logic          tx_byte_dv,
  input  logic          tx_active,
  input  logic          tx_byte_done
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SEND0 = 3'd2,
    S_WAIT0 = 3'd3,
    S_SEND1 = 3'd4,
    S_WAIT1 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, overflow_q, done_q;
  logic [DW-1:0] word_q;
  logic          pop, push, drop;
  logic          dv_d, done_d;
  logic [BW-1:0] byte_d, first_byte, second_byte;

`ifdef UART_WORD_TX_MSB_FIRST_EN
  assign first_byte  = word_q[15:8];
  assign second_byte = word_q[7:0];
`else
  assign first_byte  = word_q[7:0];
  assign second_byte = word_q[15:8];
`endif

  // A push at full is still accepted when the idle pop frees a slot this cycle.
  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  assign push = word_if.data_send_valid && (!full_q || pop);
  assign drop = word_if.data_send_valid && !push;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO storage; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (rstb && push) begin
      mem[wr_ptr_q] <= word_if.data_send;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the in-flight word.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        word_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a SENDx state exits once its strobe has been presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop)          state_d = S_LOAD;
      S_LOAD:                    state_d = S_SEND0;
      S_SEND0: if (tx_byte_dv)   state_d = S_WAIT0;
      S_WAIT0: if (tx_byte_done) state_d = S_SEND1;
      S_SEND1: if (tx_byte_dv)   state_d = S_WAIT1;
      S_WAIT1: if (tx_byte_done) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // Next output values, decoded from the state being entered.
  always_comb begin
    dv_d   = 1'b0;
    done_d = 1'b0;
    byte_d = tx_byte;
    if (((state_d == S_SEND0) || (state_d == S_SEND1)) && !tx_active) begin
      dv_d   = 1'b1;
      byte_d = (state_d == S_SEND0) ? first_byte : second_byte;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tx_byte    <= '0;
      tx_byte_dv <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_byte    <= byte_d;
      tx_byte_dv <= dv_d;
      done_q     <= done_d;
    end
  end

  assign word_if.data_send_done = done_q;
  assign word_if.fifo_full      = full_q;
  assign word_if.fifo_count     = count_q;
  assign word_if.overflow       = overflow_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: transaction-level model plus directed scenarios.
module tb_uart_word_tx;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic [7:0] tx_byte;
  logic       tx_byte_dv;
  logic       tx_active;
  logic       tx_byte_done;

  uart_word_tx_if #(.FIFO_DEPTH(DEPTH)) wif ();

  uart_word_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .word_if      (wif),
    .tx_byte      (tx_byte),
    .tx_byte_dv   (tx_byte_dv),
    .tx_active    (tx_active),
    .tx_byte_done (tx_byte_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] first_of(input logic [15:0] w);
`ifdef UART_WORD_TX_MSB_FIRST_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  function automatic logic [7:0] second_of(input logic [15:0] w);
`ifdef UART_WORD_TX_MSB_FIRST_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  // UART byte transmitter model: done pulse 20 cycles after each accepted strobe.
  bit   uart_hold   = 1'b0;
  bit   hold_active = 1'b0;
  bit   u_busy      = 1'b0;
  int   u_cnt       = 0;
  int   fall_cyc    = 0;
  int   udone_cyc[$];
  logic new_active;

  initial begin
    tx_active    = 1'b0;
    tx_byte_done = 1'b0;
  end

  always @(negedge clk) begin
    tx_byte_done = 1'b0;
    if (u_busy) begin
      if (!uart_hold) u_cnt--;
      if (u_cnt == 0) begin
        tx_byte_done = 1'b1;
        u_busy       = 1'b0;
        udone_cyc.push_back(cyc);
      end
    end else if (tx_byte_dv === 1'b1) begin
      u_busy = 1'b1;
      u_cnt  = 20;
    end
    new_active = u_busy || hold_active;
    if (tx_active && !new_active) fall_cyc = cyc;
    tx_active = new_active;
  end

  // Word-level model: queue of buffered words, one word in flight at a time.
  logic [15:0] mq[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  byte_log[$];
  logic [15:0] done_log[$];
  int          dv_cyc[$];
  int          done_cyc[$];
  bit          m_idle = 1'b1, m_inflight = 1'b0, m_ovf = 1'b0, armed = 1'b0;
  bit          prev_dv = 1'b0, done_now, m_pop, m_push;
  logic [15:0] m_word = '0;

  always @(negedge clk) begin
    done_now = 1'b0;
    if (armed) begin
      check("fifo_count", 32'(wif.fifo_count), 32'(mq.size()));
      check("fifo_full", 32'(wif.fifo_full), 32'(mq.size() == DEPTH));
      check("overflow", 32'(wif.overflow), 32'(m_ovf));
      if (tx_byte_dv) begin
        check("dv_single_cycle", 32'(prev_dv), 32'(0));
        check("dv_expected", 32'(exp_bytes.size() != 0), 32'(1));
        if (exp_bytes.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_bytes.pop_front()));
        byte_log.push_back(tx_byte);
        dv_cyc.push_back(cyc);
      end
      if (wif.data_send_done) begin
        check("done_after_both_bytes", {30'd0, m_inflight, exp_bytes.size() == 0}, 32'd3);
        done_log.push_back(m_word);
        done_cyc.push_back(cyc);
        m_inflight = 1'b0;
        done_now   = 1'b1;
      end
    end
    prev_dv = tx_byte_dv;
    // Advance the model for the coming rising edge.
    if (!rstb) begin
      mq.delete();
      exp_bytes.delete();
      m_idle     = 1'b1;
      m_inflight = 1'b0;
      m_ovf      = 1'b0;
      armed      = 1'b1;
    end else begin
      m_pop  = m_idle && (mq.size() > 0);
      m_push = wif.data_send_valid && ((mq.size() < DEPTH) || m_pop);
      if (wif.data_send_valid && !m_push) m_ovf = 1'b1;
      if (m_pop) begin
        m_word = mq.pop_front();
        exp_bytes.push_back(first_of(m_word));
        exp_bytes.push_back(second_of(m_word));
        m_idle     = 1'b0;
        m_inflight = 1'b1;
      end
      if (m_push) mq.push_back(wif.data_send);
      if (done_now) m_idle = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] w);
    wif.data_send       = w;
    wif.data_send_valid = 1'b1;
    tick();
    wif.data_send_valid = 1'b0;
  endtask

  task automatic clear_logs();
    byte_log.delete();
    done_log.delete();
    dv_cyc.delete();
    done_cyc.delete();
    udone_cyc.delete();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    tick();
    tick();
    rstb = 1'b1;
    clear_logs();
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(done_log.size()), 32'(n));
  endtask

  logic [15:0] burst [6];
  int          write_c;

  initial begin
    burst[0] = 16'h1121; burst[1] = 16'h1222; burst[2] = 16'h1323;
    burst[3] = 16'h1424; burst[4] = 16'h1525; burst[5] = 16'h1626;
    rstb                = 1'b0;
    wif.data_send       = '0;
    wif.data_send_valid = 1'b0;
    do_reset();

    // Reset values
    check("rst_tx_byte", 32'(tx_byte), 32'(0));
    check("rst_dv", 32'(tx_byte_dv), 32'(0));
    check("rst_done", 32'(wif.data_send_done), 32'(0));
    check("rst_count", 32'(wif.fifo_count), 32'(0));

    // Single word, latencies pinned by hand
    write_c = cyc;
    write(16'hA55A);
    check("count_after_write", 32'(wif.fifo_count), 32'(1));
    wait_done(1, 200, "single_done_timeout");
    check("single_dv_count", 32'(byte_log.size()), 32'(2));
    if (byte_log.size() >= 2 && udone_cyc.size() >= 2 && done_cyc.size() >= 1) begin
`ifdef UART_WORD_TX_MSB_FIRST_EN
      check("single_byte0", 32'(byte_log[0]), 32'h A5);
      check("single_byte1", 32'(byte_log[1]), 32'h 5A);
`else
      check("single_byte0", 32'(byte_log[0]), 32'h 5A);
      check("single_byte1", 32'(byte_log[1]), 32'h A5);
`endif
      check("first_dv_latency", 32'(dv_cyc[0] - write_c), 32'd3);
      check("second_dv_latency", 32'(dv_cyc[1] - udone_cyc[0]), 32'd1);
      check("done_latency", 32'(done_cyc[0] - udone_cyc[1]), 32'd1);
    end
    check("single_done_word", 32'(done_log[0]), 32'h A55A);
    check("single_overflow", 32'(wif.overflow), 32'(0));
    repeat (5) tick();
    check("single_one_done", 32'(done_log.size()), 32'(1));

    // Byte order for 16'h1234
    clear_logs();
    write(16'h1234);
    wait_done(1, 200, "w1234_done_timeout");
    if (byte_log.size() >= 2) begin
`ifdef UART_WORD_TX_MSB_FIRST_EN
      check("w1234_byte0", 32'(byte_log[0]), 32'h 12);
      check("w1234_byte1", 32'(byte_log[1]), 32'h 34);
`else
      check("w1234_byte0", 32'(byte_log[0]), 32'h 34);
      check("w1234_byte1", 32'(byte_log[1]), 32'h 12);
`endif
    end

    // Burst of 6 with UART stalled: 1 in flight, 4 buffered, 1 dropped
    do_reset();
    uart_hold = 1'b1;
    for (int i = 0; i < 6; i++) write(burst[i]);
    tick();
    check("burst_full", 32'(wif.fifo_full), 32'(1));
    check("burst_count", 32'(wif.fifo_count), 32'(4));
    check("burst_overflow", 32'(wif.overflow), 32'(1));
    uart_hold = 1'b0;
    wait_done(5, 1000, "burst_done_timeout");
    repeat (30) tick();
    check("burst_done_total", 32'(done_log.size()), 32'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < done_log.size()) check("burst_order", 32'(done_log[i]), 32'(burst[i]));
    end

    // Push at full in the cycle of the idle pop
    do_reset();
    uart_hold = 1'b1;
    for (int i = 0; i < 5; i++) write(burst[i]);
    tick();
    check("prefill_full", 32'(wif.fifo_full), 32'(1));
    uart_hold = 1'b0;
    begin
      int k = 0;
      while (done_log.size() < 1 && k < 200) begin
        tick();
        k++;
      end
    end
    check("prefill_first_done", 32'(done_log.size()), 32'(1));
    write(16'h7E57);
    check("push_pop_count", 32'(wif.fifo_count), 32'(4));
    check("push_pop_full", 32'(wif.fifo_full), 32'(1));
    check("push_pop_overflow", 32'(wif.overflow), 32'(0));
    wait_done(6, 1000, "push_pop_done_timeout");
    if (done_log.size() >= 6) check("push_pop_last_word", 32'(done_log[5]), 32'h 7E57);

    // tx_active held high while in SEND0
    do_reset();
    hold_active = 1'b1;
    tick();
    write(16'hC3D4);
    repeat (50) tick();
    check("hold_no_dv", 32'(byte_log.size()), 32'(0));
    hold_active = 1'b0;
    repeat (3) tick();
    check("hold_dv_seen", 32'(byte_log.size()), 32'(1));
    if (dv_cyc.size() >= 1) check("hold_release_latency", 32'(dv_cyc[0] - fall_cyc), 32'd1);
    wait_done(1, 200, "hold_done_timeout");

    // Reset while in WAIT1 with two words queued
    do_reset();
    write(16'h0A0B);
    write(16'h0C0D);
    write(16'h0E0F);
    begin
      int k = 0;
      while (byte_log.size() < 2 && k < 200) begin
        tick();
        k++;
      end
    end
    repeat (3) tick();
    check("pre_reset_count", 32'(wif.fifo_count), 32'(2));
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check("midrst_tx_byte", 32'(tx_byte), 32'(0));
    check("midrst_dv", 32'(tx_byte_dv), 32'(0));
    check("midrst_done", 32'(wif.data_send_done), 32'(0));
    check("midrst_count", 32'(wif.fifo_count), 32'(0));
    check("midrst_full", 32'(wif.fifo_full), 32'(0));
    check("midrst_overflow", 32'(wif.overflow), 32'(0));
    clear_logs();
    repeat (25) tick();
    check("stray_done_ignored", 32'(byte_log.size() + done_log.size()), 32'(0));
    write(16'hBEEF);
    wait_done(1, 200, "beef_done_timeout");
    check("beef_word", 32'(done_log[0]), 32'h BEEF);
    if (byte_log.size() >= 2) begin
`ifdef UART_WORD_TX_MSB_FIRST_EN
      check("beef_byte0", 32'(byte_log[0]), 32'h BE);
`else
      check("beef_byte0", 32'(byte_log[0]), 32'h EF);
`endif
    end
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Transmit-side word serializer between the core's 16-bit output handshake and the byte-level UART transmitter. It buffers 16-bit words in a small FIFO, then sends each word as two bytes through the UART TX byte interface. It signals completion of each word upstream with a one-cycle done pulse. It sits between `core` (`data_out`/`data_out_valid`/`tx_done`) and the `UART_TX` instance inside the transceiver.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: word FIFO depth; power of two, 2..16.
- `CW`, $clog2(FIFO_DEPTH+1): width of `fifo_count`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rstb` in 1: reset, synchronous, active-low.
- `data_send` in 16: word to transmit; sampled when `data_send_valid`=1.
- `data_send_valid` in 1: one-cycle write strobe.
- `data_send_done` out 1: one-cycle pulse after both bytes of a word are transmitted.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` words.
- `fifo_count` out CW: number of words buffered, excluding the word in flight.
- `overflow` out 1: sticky; set when a write is dropped.
- `tx_byte` out 8: byte to UART_TX.
- `tx_byte_dv` out 1: one-cycle start strobe to UART_TX.
- `tx_active` in 1: UART_TX currently shifting.
- `tx_byte_done` in 1: UART_TX one-cycle pulse at the end of the stop bit.

## Operation
- FIFO write:
  - Occurs when `data_send_valid`=1 and (`fifo_full`=0 or a pop happens in the same cycle).
  - Otherwise the word is dropped, `overflow` is set, and the FIFO is unchanged.
- FIFO pop occurs only on the IDLE→LOAD transition. The popped word goes into the 16-bit register `word_q`.
- Simultaneous push and pop: count is unchanged; both operations take effect. At full, the push is accepted.
- Pointers wrap modulo `FIFO_DEPTH`. The count saturates at neither end, because the full/empty rules prevent both cases.
- State machine (one-hot or binary, registered):
  - IDLE: if count>0, pop and go to LOAD.
  - LOAD: latch `word_q`; go to SEND0.
  - SEND0: when `tx_active`=0, drive `tx_byte`=first byte and `tx_byte_dv`=1 for one cycle, then go to WAIT0. If `tx_active`=1, hold in SEND0.
  - WAIT0: on `tx_byte_done`=1, go to SEND1.
  - SEND1: same as SEND0, driving the second byte; then go to WAIT1.
  - WAIT1: on `tx_byte_done`=1, go to DONE.
  - DONE: `data_send_done`=1 for one cycle; go to IDLE.
- `tx_byte_done` outside WAIT0/WAIT1 is ignored.
- Byte order: low byte `[7:0]` first by default (see Configuration).
- `overflow` clears only on reset.
- Reset mid-word (`rstb`=0 at any rising edge):
  - State goes to IDLE; FIFO is emptied; `word_q` is cleared.
  - A byte already started in UART_TX is not aborted by this block. Its late `tx_byte_done` is ignored.

## Timing
- Reset value of every output is 0: `data_send_done`, `fifo_full`, `fifo_count`, `overflow`, `tx_byte`, `tx_byte_dv`.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Write at edge N gives `fifo_count` incremented from N+1.
- Latency from an idle block with `tx_active`=0:
  - Write at edge N: IDLE pops at N+1, LOAD at N+2, first `tx_byte_dv` visible the cycle after N+2.
  - First byte strobe is therefore 3 cycles after the write.
- Second byte `tx_byte_dv` follows 1 cycle after the first `tx_byte_done`. `data_send_done` follows 1 cycle after the second `tx_byte_done`.
- Back-to-back words: next word's first `tx_byte_dv` is 3 cycles after the previous word's `data_send_done` (DONE→IDLE→LOAD→SEND0).
- `tx_byte` holds its value from the strobe cycle until the next strobe.

## Configuration
- `UART_WORD_TX_MSB_FIRST_EN` defined: the first byte is `[15:8]`, the second `[7:0]`.
- Not defined: the first byte is `[7:0]`, the second `[15:8]`.
- No other behaviour changes.

## Test plan
- Single word, macro undefined: write 16'hA55A; UART model returns done 20 cycles after each dv. Required: dv at +3 with byte 8'h5A, dv with 8'hA5, then exactly one `data_send_done` pulse, `overflow`=0.
- Macro defined: write 16'h1234. Required: bytes 8'h12 then 8'h34.
- Burst of 6 writes on consecutive cycles, `FIFO_DEPTH`=4, UART stalled:
  - First word is popped into flight; next 4 fill the FIFO; `fifo_full`=1; 6th word is dropped; `overflow`=1.
  - After UART release, exactly 5 done pulses occur, with data in write order.
- Push at full in the same cycle as the IDLE pop: word accepted, `fifo_count` stays 4, `overflow` stays 0.
- `tx_active`=1 held 50 cycles while in SEND0: no dv until `tx_active` falls, then dv 1 cycle later.
- Reset asserted in WAIT1 with 2 words queued:
  - Required next cycle: all outputs 0, count 0.
  - A stray `tx_byte_done` is ignored.
  - A new write 16'hBEEF transmits normally.
